// File: rtl/mtsp_arb_pkg.sv
// Shared types and helpers for the MTSP AXI4 read arbiter.
package mtsp_arb_pkg;

    localparam int unsigned MAX_PORTS  = 4;
    localparam int unsigned MAX_ID_W   = 8;
    localparam int unsigned MAX_ADDR_W = 64;

    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widths are sized for the widest supported configuration; the top narrows them.
    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

endpackage

// File: rtl/mtsp_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1, modulo N.
module mtsp_rr_arbiter
    import mtsp_arb_pkg::*;
#(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = src_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int unsigned cand;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mtsp_axi_rd_arbiter.sv
// Shares one AXI4 read master among C_PORTS MTSP requesters; R beats are routed by a
// source tag prepended to ARID.
module mtsp_axi_rd_arbiter
    import mtsp_arb_pkg::*;
#(
    parameter int unsigned C_PORTS           = 3,
    parameter int unsigned C_ID_WIDTH        = 1,
    parameter int unsigned C_ADDR_WIDTH      = 36,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_MAX_OUTSTANDING = 8,
    localparam int unsigned SRC_W = src_w(C_PORTS),
    localparam int unsigned MID_W = SRC_W + C_ID_WIDTH
) (
    input  logic                            MCLK,
    input  logic                            nRST,
    input  logic [C_PORTS-1:0]              S_ARVALID,
    output logic [C_PORTS-1:0]              S_ARREADY,
    input  logic [C_PORTS*C_ID_WIDTH-1:0]   S_ARID,
    input  logic [C_PORTS*C_ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [C_PORTS*8-1:0]            S_ARLEN,
    input  logic [C_PORTS*3-1:0]            S_ARSIZE,
    input  logic [C_PORTS*2-1:0]            S_ARBURST,
    output logic [C_PORTS-1:0]              S_RVALID,
    input  logic [C_PORTS-1:0]              S_RREADY,
    output logic [C_ID_WIDTH-1:0]           S_RID,
    output logic [C_DATA_WIDTH-1:0]         S_RDATA,
    output logic [1:0]                      S_RRESP,
    output logic                            S_RLAST,
    output logic                            M_ARVALID,
    input  logic                            M_ARREADY,
    output logic [MID_W-1:0]                M_ARID,
    output logic [C_ADDR_WIDTH-1:0]         M_ARADDR,
    output logic [7:0]                      M_ARLEN,
    output logic [2:0]                      M_ARSIZE,
    output logic [1:0]                      M_ARBURST,
    input  logic                            M_RVALID,
    output logic                            M_RREADY,
    input  logic [MID_W-1:0]                M_RID,
    input  logic [C_DATA_WIDTH-1:0]         M_RDATA,
    input  logic [1:0]                      M_RRESP,
    input  logic                            M_RLAST,
    output logic                            BUSY,
    output logic                            ERR
);

    logic             m_arvalid_q, m_arvalid_d;
    ar_req_t          ar_q, ar_d;
    logic [SRC_W-1:0] ar_src_q, ar_src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [3:0]       cnt_q [C_PORTS];
    logic [3:0]       cnt_d [C_PORTS];
    logic             err_q, err_d;

    logic               load;
    logic [C_PORTS-1:0] eligible;
    logic [C_PORTS-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    ar_req_t            port_req [C_PORTS];
    logic [SRC_W-1:0]   r_src;
    logic [C_PORTS-1:0] r_hit;
    logic               r_mapped;
    logic               r_fire_last;
    logic               cnt_busy;
    logic               unused_ar;

    for (genvar i = 0; i < C_PORTS; i++) begin : g_port
        assign eligible[i] = S_ARVALID[i] & (cnt_q[i] < 4'(C_MAX_OUTSTANDING));
        assign port_req[i] = '{
            id:    MAX_ID_W'(S_ARID[i*C_ID_WIDTH +: C_ID_WIDTH]),
            addr:  MAX_ADDR_W'(S_ARADDR[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]),
            len:   S_ARLEN[i*8 +: 8],
            size:  S_ARSIZE[i*3 +: 3],
            burst: S_ARBURST[i*2 +: 2]
        };
        assign r_hit[i] = (r_src == SRC_W'(i));
    end

    assign load = ~m_arvalid_q | M_ARREADY;

    mtsp_rr_arbiter #(
        .N(C_PORTS)
    ) u_rr (
        .req(eligible),
        .ptr(ptr_q),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    assign S_ARREADY = load ? gnt : '0;

    always_comb begin
        m_arvalid_d = m_arvalid_q;
        ar_d        = ar_q;
        ar_src_d    = ar_src_q;
        ptr_d       = ptr_q;
        if (load) begin
            m_arvalid_d = |gnt;
            if (|gnt) begin
                ar_d     = port_req[gnt_idx];
                ar_src_d = gnt_idx;
                ptr_d    = gnt_idx;
            end
        end
    end

    // Beats carrying an out-of-range source are accepted and discarded.
    assign r_src       = M_RID[MID_W-1 -: SRC_W];
    assign r_mapped    = |r_hit;
    assign S_RVALID    = {C_PORTS{M_RVALID}} & r_hit;
    assign M_RREADY    = r_mapped ? |(r_hit & S_RREADY) : 1'b1;
    assign r_fire_last = M_RVALID & M_RREADY & M_RLAST;
    assign S_RID       = M_RID[C_ID_WIDTH-1:0];
    assign S_RDATA     = M_RDATA;
    assign S_RRESP     = M_RRESP;
    assign S_RLAST     = M_RLAST;

    always_comb begin
        cnt_busy = 1'b0;
        for (int unsigned i = 0; i < C_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (S_ARREADY[i] && !(r_fire_last && r_hit[i])) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (!S_ARREADY[i] && r_fire_last && r_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
            cnt_busy = cnt_busy | (|cnt_q[i]);
        end
    end

    assign err_d = err_q | (M_RVALID & ~r_mapped);

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            m_arvalid_q <= 1'b0;
            ar_q        <= '0;
            ar_src_q    <= '0;
            ptr_q       <= SRC_W'(C_PORTS - 1);
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < C_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            m_arvalid_q <= m_arvalid_d;
            ar_q        <= ar_d;
            ar_src_q    <= ar_src_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign M_ARVALID = m_arvalid_q;
    assign M_ARID    = {ar_src_q, ar_q.id[C_ID_WIDTH-1:0]};
    assign M_ARADDR  = ar_q.addr[C_ADDR_WIDTH-1:0];
    assign M_ARLEN   = ar_q.len;
    assign M_ARSIZE  = ar_q.size;
    assign M_ARBURST = ar_q.burst;
    assign BUSY      = m_arvalid_q | cnt_busy;
    assign ERR       = err_q;
    assign unused_ar = ^ar_q;

endmodule

// File: tb/tb_mtsp_axi_rd_arbiter.sv
// Directed self-checking bench for mtsp_axi_rd_arbiter with default parameters.
module tb_mtsp_axi_rd_arbiter;

    logic         MCLK = 1'b0;
    logic         nRST;
    logic [2:0]   S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [2:0]   S_ARID;
    logic [107:0] S_ARADDR;
    logic [23:0]  S_ARLEN;
    logic [8:0]   S_ARSIZE;
    logic [5:0]   S_ARBURST;
    logic [0:0]   S_RID;
    logic [511:0] S_RDATA, M_RDATA;
    logic [1:0]   S_RRESP, M_RRESP;
    logic         S_RLAST, M_RLAST;
    logic         M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [2:0]   M_ARID, M_RID;
    logic [35:0]  M_ARADDR;
    logic [7:0]   M_ARLEN;
    logic [2:0]   M_ARSIZE;
    logic [1:0]   M_ARBURST;
    logic         BUSY, ERR;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 MCLK = ~MCLK;

    mtsp_axi_rd_arbiter #(
        .C_PORTS(3),
        .C_ID_WIDTH(1),
        .C_ADDR_WIDTH(36),
        .C_DATA_WIDTH(512),
        .C_MAX_OUTSTANDING(8)
    ) dut (
        .MCLK(MCLK), .nRST(nRST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
        .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARID(M_ARID), .M_ARADDR(M_ARADDR),
        .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RID(M_RID), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .BUSY(BUSY), .ERR(ERR)
    );

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic clear_inputs();
        S_ARVALID = '0; S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0;
        S_ARSIZE = '0; S_ARBURST = '0; S_RREADY = '0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RID = '0; M_RDATA = '0;
        M_RRESP = '0; M_RLAST = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic set_port(input int p, input logic [35:0] addr, input logic id,
                            input logic [7:0] len);
        S_ARADDR[p*36 +: 36] = addr;
        S_ARID[p]            = id;
        S_ARLEN[p*8 +: 8]    = len;
        S_ARSIZE[p*3 +: 3]   = 3'd6;
        S_ARBURST[p*2 +: 2]  = 2'd1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        n_checks++;
        if (M_ARVALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_arvalid: got %b expected 0", M_ARVALID);
        end
        n_checks++;
        if ({M_ARID, M_ARADDR, M_ARLEN} !== '0) begin
            n_fail++; $display("FAIL reset_fields: got %h/%h/%h expected 0", M_ARID, M_ARADDR, M_ARLEN);
        end
        n_checks++;
        if ({BUSY, ERR} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_err: got %b expected 00", {BUSY, ERR});
        end
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        logic [511:0] beat_data;
        do_reset();
        set_port(1, 36'h1_2345_6780, 1'b1, 8'd3);
        S_ARVALID = 3'b010;
        M_ARREADY = 1'b1;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b010) begin
            n_fail++; $display("FAIL single_arready: got %b expected 010", S_ARREADY);
        end
        tick();
        S_ARVALID = '0;
        #1;
        n_checks++;
        if (M_ARVALID !== 1'b1 || M_ARID !== 3'b011) begin
            n_fail++; $display("FAIL single_arid: got v=%b id=%b expected v=1 id=011", M_ARVALID, M_ARID);
        end
        n_checks++;
        if (M_ARADDR !== 36'h1_2345_6780 || M_ARLEN !== 8'd3 || M_ARSIZE !== 3'd6 ||
            M_ARBURST !== 2'd1) begin
            n_fail++; $display("FAIL single_arfields: got %h/%h/%h/%h expected 123456780/03/6/1",
                               M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST);
        end
        tick();
        for (int b = 0; b < 4; b++) begin
            beat_data = {16{32'hA5A5_0000 | b}};
            M_RVALID  = 1'b1;
            M_RID     = 3'b011;
            M_RDATA   = beat_data;
            M_RRESP   = 2'(b);
            M_RLAST   = (b == 3);
            S_RREADY  = 3'b010;
            #1;
            n_checks++;
            if (S_RVALID !== 3'b010 || M_RREADY !== 1'b1) begin
                n_fail++; $display("FAIL single_rroute beat %0d: got rvalid=%b rready=%b expected 010/1",
                                   b, S_RVALID, M_RREADY);
            end
            n_checks++;
            if (S_RDATA !== beat_data || S_RID !== 1'b1 || S_RRESP !== 2'(b) ||
                S_RLAST !== (b == 3)) begin
                n_fail++; $display("FAIL single_rpayload beat %0d: got id=%b resp=%b last=%b",
                                   b, S_RID, S_RRESP, S_RLAST);
            end
            n_checks++;
            if (BUSY !== 1'b1 || M_ARVALID !== 1'b0) begin
                n_fail++; $display("FAIL single_busy beat %0d: got busy=%b arvalid=%b expected 1/0",
                                   b, BUSY, M_ARVALID);
            end
            tick();
        end
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        #1;
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_drop: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_rdy;
        logic [1:0]  exp_src;
        logic [35:0] exp_addr;
        do_reset();
        for (int p = 0; p < 3; p++) set_port(p, 36'(p * 'h1000), 1'b0, 8'd0);
        S_ARVALID = 3'b111;
        M_ARREADY = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            exp_rdy = 3'(1 << (k % 3));
            n_checks++;
            if (S_ARREADY !== exp_rdy) begin
                n_fail++; $display("FAIL rr_grant %0d: got %b expected %b", k, S_ARREADY, exp_rdy);
            end
            if (k > 0) begin
                exp_src  = 2'((k - 1) % 3);
                exp_addr = 36'(((k - 1) % 3) * 'h1000);
                n_checks++;
                if (M_ARVALID !== 1'b1 || M_ARID[2:1] !== exp_src || M_ARADDR !== exp_addr) begin
                    n_fail++; $display("FAIL rr_issue %0d: got v=%b src=%0d addr=%h expected 1/%0d/%h",
                                       k, M_ARVALID, M_ARID[2:1], M_ARADDR, exp_src, exp_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_port(0, 36'hA_0000_0000, 1'b0, 8'd0);
        set_port(1, 36'hB_0000_0000, 1'b1, 8'd5);
        S_ARVALID = 3'b001;
        M_ARREADY = 1'b0;
        tick();
        S_ARVALID = 3'b011;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (S_ARREADY !== 3'b000 || M_ARVALID !== 1'b1 || M_ARADDR !== 36'hA_0000_0000 ||
                M_ARID !== 3'b000) begin
                n_fail++; $display("FAIL stall_hold %0d: got rdy=%b v=%b addr=%h id=%b", c,
                                   S_ARREADY, M_ARVALID, M_ARADDR, M_ARID);
            end
            tick();
        end
        M_ARREADY = 1'b1;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b010) begin
            n_fail++; $display("FAIL stall_resume: got %b expected 010", S_ARREADY);
        end
        tick();
        S_ARVALID = '0;
        #1;
        n_checks++;
        if (M_ARADDR !== 36'hB_0000_0000 || M_ARID !== 3'b011 || M_ARLEN !== 8'd5) begin
            n_fail++; $display("FAIL stall_next: got addr=%h id=%b len=%h expected b00000000/011/05",
                               M_ARADDR, M_ARID, M_ARLEN);
        end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        for (int p = 0; p < 3; p++) set_port(p, 36'(p * 'h100), 1'b0, 8'd0);
        S_ARVALID = 3'b100;
        M_ARREADY = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            n_checks++;
            if (S_ARREADY !== 3'b100) begin
                n_fail++; $display("FAIL limit_fill %0d: got %b expected 100", n, S_ARREADY);
            end
            tick();
        end
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b000) begin
            n_fail++; $display("FAIL limit_block: got %b expected 000", S_ARREADY);
        end
        S_ARVALID = 3'b111;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b001) begin
            n_fail++; $display("FAIL limit_others0: got %b expected 001", S_ARREADY);
        end
        tick();
        M_RVALID = 1'b1;
        M_RID    = 3'b100;
        M_RLAST  = 1'b1;
        S_RREADY = 3'b100;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b010 || S_RVALID !== 3'b100) begin
            n_fail++; $display("FAIL limit_others1: got rdy=%b rvalid=%b expected 010/100",
                               S_ARREADY, S_RVALID);
        end
        tick();
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b100) begin
            n_fail++; $display("FAIL limit_release: got %b expected 100", S_ARREADY);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_port(0, 36'h0_0000_0040, 1'b0, 8'd0);
        S_ARVALID = 3'b001;
        M_ARREADY = 1'b1;
        for (int n = 0; n < 7; n++) tick();
        M_RVALID = 1'b1;
        M_RID    = 3'b000;
        M_RLAST  = 1'b1;
        S_RREADY = 3'b001;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b001) begin
            n_fail++; $display("FAIL same_grant: got %b expected 001", S_ARREADY);
        end
        tick();
        M_RVALID = 1'b0;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b001) begin
            n_fail++; $display("FAIL same_hold7: got %b expected 001", S_ARREADY);
        end
        tick();
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b000) begin
            n_fail++; $display("FAIL same_at8: got %b expected 000", S_ARREADY);
        end
        M_RVALID = 1'b1;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b000) begin
            n_fail++; $display("FAIL same_no_bypass: got %b expected 000", S_ARREADY);
        end
        tick();
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        #1;
        n_checks++;
        if (S_ARREADY !== 3'b001) begin
            n_fail++; $display("FAIL same_retired: got %b expected 001", S_ARREADY);
        end
    endtask

    task automatic test_unmapped_and_reset();
        do_reset();
        M_RVALID = 1'b1;
        M_RID    = 3'b110;
        S_RREADY = 3'b000;
        #1;
        n_checks++;
        if (M_RREADY !== 1'b1 || S_RVALID !== 3'b000 || ERR !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_drop: got rready=%b rvalid=%b err=%b expected 1/000/0",
                               M_RREADY, S_RVALID, ERR);
        end
        tick();
        M_RVALID = 1'b0;
        #1;
        n_checks++;
        if (ERR !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_err: got %b expected 1", ERR);
        end
        tick();
        n_checks++;
        if (ERR !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_sticky: got %b expected 1", ERR);
        end
        set_port(1, 36'h7_7777_7770, 1'b1, 8'd7);
        S_ARVALID = 3'b010;
        M_ARREADY = 1'b0;
        tick();
        S_ARVALID = '0;
        M_RVALID  = 1'b1;
        M_RID     = 3'b011;
        S_RREADY  = 3'b010;
        #1;
        n_checks++;
        if (M_ARVALID !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: got v=%b busy=%b expected 1/1", M_ARVALID, BUSY);
        end
        nRST = 1'b0;
        #1;
        n_checks++;
        if (M_ARVALID !== 1'b0 || M_ARID !== 3'b000 || M_ARADDR !== 36'h0 || M_ARLEN !== 8'h0) begin
            n_fail++; $display("FAIL midreset_ar: got v=%b id=%b addr=%h len=%h expected all 0",
                               M_ARVALID, M_ARID, M_ARADDR, M_ARLEN);
        end
        n_checks++;
        if (BUSY !== 1'b0 || ERR !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got busy=%b err=%b expected 0/0", BUSY, ERR);
        end
        clear_inputs();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_outstanding_limit();
        test_same_cycle();
        test_unmapped_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
